// File: rtl/fetch_sequencer.sv
// fetch_sequencer: handshaked fetch-stage control FSM.
// Walks PC -> MAR -> program memory -> MDR -> IR, holds the fetched
// instruction on ir_valid until decode takes it, and hands program memory
// to the loader only between fetches.
module fetch_sequencer #(
    parameter int ADDR_W     = 5,
    parameter int PM_DEPTH   = 6,
    parameter int PM_LATENCY = 1,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              halt,
    input  logic [ADDR_W-1:0] pc_addr,
    input  logic              pm_load_req,
    input  logic              ir_ready,
    output logic              pm_load_gnt,
    output logic              mar_wr,
    output logic              pm_rd,
    output logic              mdr_wr,
    output logic              mdr_rd,
    output logic              ir_wr,
    output logic              pc_inc,
    output logic              pc_clr,
    output logic              ir_valid,
    output logic              busy,
    output logic [CNT_W-1:0]  fetch_count
);

    // Encoding 3'd7 is unused; the next-state default sends it to IDLE.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ADDR  = 3'd2,
        MEM   = 3'd3,
        MDR   = 3'd4,
        IR    = 3'd5,
        VALID = 3'd6
    } state_t;

    // Last MEM cycle index; lat_cnt is wide enough for PM_LATENCY up to 7.
    localparam logic [2:0]        LAT_LAST = 3'(PM_LATENCY - 1);
    // PC value after which the next fetch must wrap the PC to zero.
    localparam logic [ADDR_W-1:0] PC_LAST  = ADDR_W'(PM_DEPTH - 1);

    state_t     state;
    state_t     state_next;
    logic       run;
    logic       run_next;
    logic [2:0] lat_cnt;

    // halt beats start when both arrive together.
    always_comb begin
        run_next = run;
        if (halt)
            run_next = 1'b0;
        else if (start)
            run_next = 1'b1;
    end

    // State, run flag, memory-latency counter and completed-fetch counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            run         <= 1'b0;
            lat_cnt     <= 3'd0;
            fetch_count <= '0;
        end else begin
            state <= state_next;
            run   <= run_next;
            if (state == ADDR)
                lat_cnt <= 3'd0;
            else if (state == MEM)
                lat_cnt <= lat_cnt + 3'd1;
            if (state == VALID && ir_ready)
                fetch_count <= fetch_count + 1'b1;
        end
    end

    // Next-state decode; run_next lets a start/halt arriving this cycle
    // take effect at the IDLE and VALID decision points.
    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE: begin
                if (pm_load_req)
                    state_next = LOAD;
                else if (run_next)
                    state_next = ADDR;
                else
                    state_next = IDLE;
            end
            LOAD:  state_next = pm_load_req ? LOAD : IDLE;
            ADDR:  state_next = MEM;
            MEM:   state_next = (lat_cnt == LAT_LAST) ? MDR : MEM;
            MDR:   state_next = IR;
            IR:    state_next = VALID;
            VALID: begin
                if (!ir_ready)
                    state_next = VALID;
                else if (pm_load_req || !run_next)
                    state_next = IDLE;
                else
                    state_next = ADDR;
            end
            default: state_next = IDLE;
        endcase
    end

    // Moore strobes decoded purely from the state register, so an async
    // reset drops every strobe in the same instant it clears the state.
    always_comb begin
        pm_load_gnt = 1'b0;
        mar_wr      = 1'b0;
        pm_rd       = 1'b0;
        mdr_wr      = 1'b0;
        mdr_rd      = 1'b0;
        ir_wr       = 1'b0;
        pc_inc      = 1'b0;
        pc_clr      = 1'b0;
        ir_valid    = 1'b0;
        busy        = (state != IDLE);
        case (state)
            LOAD:  pm_load_gnt = 1'b1;
            ADDR:  mar_wr      = 1'b1;
            MEM:   pm_rd       = 1'b1;
            MDR:   mdr_wr      = 1'b1;
            IR: begin
                mdr_rd = 1'b1;
                ir_wr  = 1'b1;
                if (pc_addr == PC_LAST)
                    pc_clr = 1'b1;
                else
                    pc_inc = 1'b1;
            end
            VALID: ir_valid = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: reset, fetch sequence, PC wrap,
// decode back-pressure, loader arbitration, halt/start corner cases,
// async reset mid-fetch and fetch_count wrap.
module tb_fetch_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, halt, pm_load_req, ir_ready;
    logic [4:0] pc_addr;
    logic       pm_load_gnt, mar_wr, pm_rd, mdr_wr, mdr_rd, ir_wr;
    logic       pc_inc, pc_clr, ir_valid, busy;
    logic [7:0] fetch_count;
    logic [9:0] vec;

    int tests = 0;
    int fails = 0;

    // {gnt, mar_wr, pm_rd, mdr_wr, mdr_rd, ir_wr, pc_inc, pc_clr, ir_valid, busy}
    localparam logic [9:0] V_IDLE  = 10'b0000000000;
    localparam logic [9:0] V_LOAD  = 10'b1000000001;
    localparam logic [9:0] V_ADDR  = 10'b0100000001;
    localparam logic [9:0] V_MEM   = 10'b0010000001;
    localparam logic [9:0] V_MDR   = 10'b0001000001;
    localparam logic [9:0] V_IRINC = 10'b0000111001;
    localparam logic [9:0] V_IRCLR = 10'b0000110101;
    localparam logic [9:0] V_VALID = 10'b0000000011;

    fetch_sequencer #(.ADDR_W(5), .PM_DEPTH(6), .PM_LATENCY(1), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .halt(halt),
        .pc_addr(pc_addr), .pm_load_req(pm_load_req), .ir_ready(ir_ready),
        .pm_load_gnt(pm_load_gnt), .mar_wr(mar_wr), .pm_rd(pm_rd),
        .mdr_wr(mdr_wr), .mdr_rd(mdr_rd), .ir_wr(ir_wr), .pc_inc(pc_inc),
        .pc_clr(pc_clr), .ir_valid(ir_valid), .busy(busy),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    assign vec = {pm_load_gnt, mar_wr, pm_rd, mdr_wr, mdr_rd, ir_wr,
                  pc_inc, pc_clr, ir_valid, busy};

    // Stand-in for the datapath PC register driven by the strobes.
    always @(posedge clk or negedge reset) begin
        if (!reset)      pc_addr <= 5'd0;
        else if (pc_clr) pc_addr <= 5'd0;
        else if (pc_inc) pc_addr <= pc_addr + 5'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and compare the strobe vector.
    task automatic step(input logic [9:0] exp, input string tag);
        @(negedge clk);
        chk(tag, 32'(vec), 32'(exp));
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; halt = 1'b0;
        pm_load_req = 1'b0; ir_ready = 1'b0;

        // T1: reset held 3 cycles, then idle with no stimulus
        repeat (3) @(negedge clk);
        chk("t1_rst_vec", 32'(vec), 32'(V_IDLE));
        chk("t1_rst_cnt", 32'(fetch_count), 32'd0);
        reset = 1'b1;
        step(V_IDLE, "t1_idle_a");
        step(V_IDLE, "t1_idle_b");
        chk("t1_cnt", 32'(fetch_count), 32'd0);

        // T2: first fetch, one strobe per cycle, ir_valid on 5th cycle
        start = 1'b1; ir_ready = 1'b1;
        step(V_ADDR, "t2_addr");
        start = 1'b0;
        step(V_MEM,   "t2_mem");
        step(V_MDR,   "t2_mdr");
        step(V_IRINC, "t2_ir");
        step(V_VALID, "t2_valid");

        // T3: six more fetches, pc 1..5 then 0; wrap on pc 5
        for (int f = 1; f <= 6; f++) begin
            step(V_ADDR, "t3_addr");
            chk("t3_cnt", 32'(fetch_count), 32'(f));
            step(V_MEM, "t3_mem");
            step(V_MDR, "t3_mdr");
            step((f == 5) ? V_IRCLR : V_IRINC, "t3_ir");
            step(V_VALID, "t3_valid");
        end

        // T4: decode stalls 10 cycles at VALID
        step(V_ADDR, "t4_addr");
        chk("t4_cnt7", 32'(fetch_count), 32'd7);
        ir_ready = 1'b0;
        step(V_MEM,   "t4_mem");
        step(V_MDR,   "t4_mdr");
        step(V_IRINC, "t4_ir");
        for (int i = 0; i < 10; i++) begin
            step(V_VALID, "t4_hold");
            chk("t4_hold_cnt", 32'(fetch_count), 32'd7);
        end
        ir_ready = 1'b1;
        step(V_ADDR, "t4_resume");
        chk("t4_cnt8", 32'(fetch_count), 32'd8);
        ir_ready = 1'b0;

        // T5: loader request during MEM waits for the handshake and IDLE
        step(V_MEM, "t5_mem");
        pm_load_req = 1'b1;
        step(V_MDR,   "t5_mdr");
        step(V_IRINC, "t5_ir");
        step(V_VALID, "t5_valid_a");
        step(V_VALID, "t5_valid_b");
        ir_ready = 1'b1;
        step(V_IDLE, "t5_idle");
        chk("t5_cnt9", 32'(fetch_count), 32'd9);
        for (int i = 0; i < 4; i++) step(V_LOAD, "t5_load");
        pm_load_req = 1'b0;
        step(V_IDLE, "t5_idle_after");
        step(V_ADDR, "t5_resume");

        // T6: halt during MDR delivers the instruction then idles
        step(V_MEM, "t6_mem");
        step(V_MDR, "t6_mdr");
        halt = 1'b1;
        step(V_IRINC, "t6_ir");
        halt = 1'b0;
        step(V_VALID, "t6_valid");
        step(V_IDLE,  "t6_idle_a");
        chk("t6_cnt10", 32'(fetch_count), 32'd10);
        step(V_IDLE, "t6_idle_b");
        // start and halt together: halt wins
        start = 1'b1; halt = 1'b1;
        step(V_IDLE, "t6_sh_a");
        start = 1'b0; halt = 1'b0;
        step(V_IDLE, "t6_sh_b");
        // async reset during MEM drops strobes immediately
        start = 1'b1;
        step(V_ADDR, "t6_addr");
        start = 1'b0;
        step(V_MEM, "t6_mem_b");
        #2 reset = 1'b0;
        #1 chk("t6_rst_vec", 32'(vec), 32'(V_IDLE));
        chk("t6_rst_cnt", 32'(fetch_count), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step(V_IDLE, "t6_post_rst");

        // fetch_count wraps 255 -> 0
        start = 1'b1;
        step(V_ADDR, "wrap_addr");
        start = 1'b0;
        repeat (1275) @(negedge clk);
        chk("wrap_255", 32'(fetch_count), 32'd255);
        chk("wrap_255_vec", 32'(vec), 32'(V_ADDR));
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        repeat (3) @(negedge clk);
        step(V_IDLE, "wrap_idle");
        chk("wrap_0", 32'(fetch_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
